aes_key_expand_seq: RTL and testbench
=====================================

AES_KEY_EXPAND_SEQ -- requirements
Module: aes_key_expand_seq

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, round-key output buffer depth in entries (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to expand key_in in mode; sampled only while busy=0.
REQ-005 SHALL have port mode  input  2  key size: 00=128, 01=192, 10=256, 11=illegal.
REQ-006 SHALL have port key_in  input  256  cipher key, MSB-aligned; a 128-bit key uses [255:128] and a 192-bit key uses [255:64].
REQ-007 SHALL have port busy  output  1  expansion in progress or round keys still undelivered.
REQ-008 SHALL have port err  output  1  one-cycle pulse when start is rejected for an illegal mode.
REQ-009 SHALL have port rk_valid  output  1  rk_data and rk_idx hold a valid round key.
REQ-010 SHALL have port rk_ready  input  1  consumer accepts the round key.
REQ-011 SHALL have port rk_data  output  128  round key, {w[4j],w[4j+1],w[4j+2],w[4j+3]}.
REQ-012 SHALL have port rk_idx  output  4  round-key index j, 0..Nr.
REQ-013 SHALL have port done  output  1  one-cycle pulse on the handshake that delivers round key Nr.

Function
REQ-014 Nk/Nr SHALL be 4/10, 6/12 and 8/14 for modes 00/01/10; the total word count SHALL be 4*(Nr+1) (44/52/60).
REQ-015 start=1 with busy=0 and a legal mode SHALL latch key_in and mode at that edge (E0), set busy and clear the word counter i.
REQ-016 One word w[i] SHALL be registered per non-stalled cycle; with no stalls, w[i] SHALL be written at edge E(i+1).
REQ-017 w[i] for i<Nk SHALL be taken from the latched key, most-significant word first.
REQ-018 For i>=Nk and i mod Nk=0: w[i]=w[i-Nk]^SubWord(RotWord(w[i-1]))^{Rcon[i/Nk],24'h0}.
REQ-019 For Nk=8 and i mod 8=4: w[i]=w[i-8]^SubWord(w[i-1]); otherwise w[i]=w[i-Nk]^w[i-1].
REQ-020 Rcon SHALL start at 8'h01 and double in GF(2^8) (xtime, reduction polynomial 0x11B) after each use: 01,02,..,80,1B,36.
REQ-021 Only an 8-word sliding window of history SHALL be stored, never the full schedule.
REQ-022 Words 4j..4j+3 SHALL be pushed to the FIFO with rk_idx=j at the edge that writes w[4j+3]; rk_valid SHALL rise in the following cycle (first key 4 cycles after E0).
REQ-023 Generation SHALL stall, holding i and the window, in any cycle where i mod 4=3, the FIFO is full and no pop occurs that cycle; a simultaneous push and pop on a full FIFO SHALL be allowed.
REQ-024 Pop SHALL occur when rk_valid and rk_ready are both 1; rk_data/rk_idx SHALL stay stable while rk_valid=1 and rk_ready=0.
REQ-025 done SHALL pulse on the pop of index Nr; busy SHALL fall in the same cycle as done and be 0 the cycle after.
REQ-026 start while busy=1 SHALL be ignored with no err pulse.
REQ-027 start with an illegal mode SHALL not change state and SHALL pulse err for one cycle.
REQ-028 SubWord SHALL use four combinational AES S-box lookups; the block SHALL have no multi-cycle paths.

Reset
REQ-029 rst=1 SHALL, at the next edge, empty the FIFO, clear i, the window and Rcon, and drive busy=0, err=0, rk_valid=0, rk_data=0, rk_idx=0 and done=0.
REQ-030 Reset mid-expansion SHALL abort with no done pulse; start in the same cycle as rst SHALL be ignored.

Configuration
REQ-031 With macro AES_KEYEXP_WIDE_KEY_EN defined, modes 00, 01 and 10 SHALL be legal.
REQ-032 Without AES_KEYEXP_WIDE_KEY_EN, only mode 00 SHALL be legal; 01 and 10 SHALL be treated as illegal (REQ-027).
REQ-033 Without AES_KEYEXP_WIDE_KEY_EN, the window SHALL shrink to 4 words, the Nk=6/8 logic SHALL be removed, and key_in[127:0] SHALL be unused.

Verification
REQ-034 Mode 00 test: key 2b7e151628aed2a6abf7158809cf4f3c with rk_ready=1 -> 11 keys at consecutive 4-cycle spacing; idx 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; done on idx 10.
REQ-035 Mode 01 test: key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> 13 keys; idx 12 = e98ba06f448c773c8ecc720401002202.
REQ-036 Mode 10 test: key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> 15 keys; idx 14 = fe4890d1e6188d0b046df344706c631e.
REQ-037 Backpressure test: rk_ready=0 for 40 cycles, then 1 -> generation stalls at FIFO_DEPTH keys; delivered sequence identical to REQ-034; no key lost or duplicated.
REQ-038 Illegal-mode test: start with mode=11 -> one-cycle err, busy stays 0. Reset test: rst at cycle 20 of a mode-00 run -> all outputs 0 next cycle, no done; a new start then completes normally.
REQ-039 Config test: build without AES_KEYEXP_WIDE_KEY_EN and start with mode=10 -> err pulses and no rk_valid.

Source files
------------

// File: rtl/aes_key_expand_seq.sv
// AES key schedule generator: one word w[i] per cycle, round keys streamed out through a small FIFO.
// Optional feature macro AES_KEYEXP_WIDE_KEY_EN enables 192/256-bit keys; default build is AES-128 only.
//   state   | meaning
//   S_IDLE  | waiting for start, FIFO empty
//   S_GEN   | producing w[i], pushing a round key every fourth word
//   S_DRAIN | schedule complete, waiting for the consumer to take the remaining keys
module aes_key_expand_seq #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         err,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_idx,
  output logic         done
);

`ifdef AES_KEYEXP_WIDE_KEY_EN
  localparam int WIN = 8;
  localparam int KW  = 256;
`else
  localparam int WIN = 4;
  localparam int KW  = 128;
`endif
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = FIFO_DEPTH[PW:0];

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_DRAIN} state_t;

  state_t        state_q, state_d;
  logic [5:0]    i_q, i_d;
  logic [2:0]    kc_q, kc_d;
  logic [7:0]    rcon_q, rcon_d;
  logic [KW-1:0] key_q, key_d;
  logic [31:0]   win_q [WIN];
  logic [31:0]   win_d [WIN];
  logic          err_q;

  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0]   cnt_q;
  logic [131:0]  fifo_mem [FIFO_DEPTH];
  logic [131:0]  head;

  logic          legal_mode, sub_mid;
  logic [3:0]    nk, nr;
  logic [31:0]   w_old, w_prev, w_sub, w_new;
  logic          pop, push, fifo_full, word_last, gen_adv, accept;

`ifdef AES_KEYEXP_WIDE_KEY_EN
  logic [1:0] mode_q, mode_d;

  always_comb begin
    legal_mode = (mode != 2'b11);
    nk         = 4'd4;
    nr         = 4'd10;
    w_old      = win_q[3];
    sub_mid    = 1'b0;
    case (mode_q)
      2'b01: begin
        nk    = 4'd6;
        nr    = 4'd12;
        w_old = win_q[5];
      end
      2'b10: begin
        nk      = 4'd8;
        nr      = 4'd14;
        w_old   = win_q[7];
        sub_mid = (kc_q == 3'd4);
      end
      default: ;
    endcase
  end
`else
  // Low half of the key bus only carries 192/256-bit key material.
  logic unused_key_lo;
  assign unused_key_lo = ^key_in[127:0];

  always_comb begin
    legal_mode = (mode == 2'b00);
    nk         = 4'd4;
    nr         = 4'd10;
    w_old      = win_q[3];
    sub_mid    = 1'b0;
  end
`endif

  always_comb begin
    w_prev = win_q[0];
    w_sub  = sub_word((kc_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev);
    w_new  = w_old ^ w_prev;
    if (i_q < {2'b00, nk}) begin
      w_new = key_q[KW-1 -: 32];
    end else if (kc_q == 3'd0) begin
      w_new = w_old ^ w_sub ^ {rcon_q, 24'h0};
    end else if (sub_mid) begin
      w_new = w_old ^ w_sub;
    end
  end

  assign head      = fifo_mem[rd_q];
  assign rk_valid  = (cnt_q != '0);
  assign rk_data   = rk_valid ? head[127:0] : 128'h0;
  assign rk_idx    = rk_valid ? head[131:128] : 4'h0;
  assign pop       = rk_valid && rk_ready;
  assign fifo_full = (cnt_q == FULL_CNT);
  assign word_last = (i_q[1:0] == 2'b11);
  // A key-completing word may only be written if its FIFO slot exists this cycle.
  assign gen_adv   = (state_q == S_GEN) && !(word_last && fifo_full && !pop);
  assign push      = gen_adv && word_last;
  assign done      = pop && (state_q == S_DRAIN) && (rk_idx == nr);
  assign busy      = (state_q != S_IDLE) && !done;
  assign accept    = start && !busy && legal_mode;
  assign err       = err_q;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    kc_d    = kc_q;
    rcon_d  = rcon_q;
    key_d   = key_q;
    win_d   = win_q;
`ifdef AES_KEYEXP_WIDE_KEY_EN
    mode_d  = mode_q;
`endif
    if (accept) begin
      state_d = S_GEN;
      i_d     = 6'd0;
      kc_d    = 3'd0;
      rcon_d  = 8'h01;
      key_d   = key_in[255 -: KW];
`ifdef AES_KEYEXP_WIDE_KEY_EN
      mode_d  = mode;
`endif
    end else begin
      case (state_q)
        S_GEN: begin
          if (gen_adv) begin
            i_d      = i_q + 6'd1;
            kc_d     = (kc_q == nk[2:0] - 3'd1) ? 3'd0 : kc_q + 3'd1;
            key_d    = key_q << 32;
            win_d[0] = w_new;
            for (int k = 1; k < WIN; k++) win_d[k] = win_q[k-1];
            if (kc_q == 3'd0 && !(i_q < {2'b00, nk})) rcon_d = xtime(rcon_q);
            if (i_q == {nr, 2'b11}) state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (done) state_d = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      kc_q    <= '0;
      rcon_q  <= '0;
      key_q   <= '0;
      err_q   <= 1'b0;
      for (int k = 0; k < WIN; k++) win_q[k] <= '0;
`ifdef AES_KEYEXP_WIDE_KEY_EN
      mode_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      kc_q    <= kc_d;
      rcon_q  <= rcon_d;
      key_q   <= key_d;
      err_q   <= start && !busy && !legal_mode;
      win_q   <= win_d;
`ifdef AES_KEYEXP_WIDE_KEY_EN
      mode_q  <= mode_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_q] <= {i_q[5:2], win_q[2], win_q[1], win_q[0], w_new};
  end

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Self-checking bench for aes_key_expand_seq: reference key schedule with its own GF(2^8)-derived S-box,
// expected round keys queued at start and compared on every rk_valid/rk_ready handshake.
module tb_aes_key_expand_seq;
  logic         clk = 1'b0;
  logic         rst, start, rk_ready;
  logic [1:0]   mode;
  logic [255:0] key_in;
  logic         busy, err, rk_valid, done;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int n_done = 0;
  logic [7:0]   sb [256];
  logic [131:0] exp_q [$];
  logic [3:0]   exp_nr = 4'd10;
  int           pop_cyc [$];
  logic [127:0] last_data = '0;
  logic [131:0] mon_e;
  logic         prev_stall = 1'b0;
  logic [131:0] prev_out = '0;

  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEYZ   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};

  aes_key_expand_seq #(.FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .key_in(key_in),
    .busy(busy), .err(err), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_data(rk_data), .rk_idx(rk_idx), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [31:0] sub4(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, xb, yb;
    for (int x = 0; x < 256; x++) begin
      xb = x[7:0];
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        yb = y[7:0];
        if (xb != 8'h00 && gmul(xb, yb) == 8'h01) inv = yb;
      end
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic push_expected(input logic [1:0] m, input logic [255:0] key);
    int nk, nr;
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    nk = (m == 2'b00) ? 4 : (m == 2'b01) ? 6 : 8;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) begin
        w[i] = key[255 - 32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = sub4({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = gmul(rc, 8'h02);
        end else if (nk == 8 && i % nk == 4) begin
          t = sub4(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int j = 0; j <= nr; j++) exp_q.push_back({j[3:0], w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]});
    exp_nr = nr[3:0];
  endtask

  task automatic chk(input string tag, input logic [131:0] obs, input logic [131:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [1:0] m, input logic [255:0] k);
    mode = m; key_in = k; start = 1'b1;
    push_expected(m, k);
    pop_cyc.delete();
    tick();
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k, d0;
    k = 0; d0 = n_done;
    while (n_done == d0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk({tag, "_done_seen"}, 132'(n_done), 132'(d0 + 1));
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, {busy, err, rk_valid, done, rk_idx, rk_data}, '0);
  endtask

  task automatic illegal_start(input logic [1:0] m, input string tag);
    logic seen_valid;
    mode = m; start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk({tag, "_err_pulse"}, 132'(err), 132'(1));
    chk({tag, "_busy"}, 132'(busy), 132'(0));
    @(negedge clk);
    chk({tag, "_err_clear"}, 132'(err), 132'(0));
    seen_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rk_valid) seen_valid = 1'b1;
    end
    chk({tag, "_no_valid"}, 132'(seen_valid), 132'(0));
  endtask

  // Scoreboard side: compare every delivered key, output stability under stall, and done placement.
  always @(negedge clk) begin
    if (prev_stall && rk_valid) begin
      checks++;
      assert ({rk_idx, rk_data} === prev_out) else begin
        errors++;
        $error("FAIL stall_stable: observed %0h expected %0h", {rk_idx, rk_data}, prev_out);
      end
    end
    prev_stall = rk_valid && !rk_ready;
    prev_out   = {rk_idx, rk_data};
    if (done === 1'b1) n_done++;
    if (rk_valid && rk_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL sb_unexpected_key: observed %0h expected none", {rk_idx, rk_data});
      end else begin
        mon_e = exp_q.pop_front();
        assert ({rk_idx, rk_data} === mon_e) else begin
          errors++;
          $error("FAIL sb_key: observed %0h expected %0h", {rk_idx, rk_data}, mon_e);
        end
        checks++;
        assert (done === (mon_e[131:128] == exp_nr)) else begin
          errors++;
          $error("FAIL sb_done: observed %0b expected %0b", done, mon_e[131:128] == exp_nr);
        end
        if (mon_e[131:128] == exp_nr) begin
          checks++;
          assert (busy === 1'b0) else begin
            errors++;
            $error("FAIL busy_with_done: observed %0b expected 0", busy);
          end
        end
        pop_cyc.push_back(cyc);
        last_data = rk_data;
      end
    end else begin
      checks++;
      assert (done === 1'b0) else begin
        errors++;
        $error("FAIL stray_done: observed %0b expected 0", done);
      end
    end
  end

  initial begin
    logic spacing_ok;
    int   d_before;
    build_sbox();
    rst = 1'b1; start = 1'b1; mode = 2'b00; key_in = KEY128; rk_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk_idle("reset_state");
    @(negedge clk);
    chk_idle("start_during_reset_ignored");

    // Mode 00, free-flowing consumer
    start_run(2'b00, KEY128);
    @(negedge clk);
    chk("a_busy_after_start", 132'(busy), 132'(1));
    chk("a_no_valid_yet", 132'(rk_valid), 132'(0));
    wait_done(80, "a");
    chk("a_sb_drained", 132'(exp_q.size()), 132'(0));
    chk("a_key_count", 132'(pop_cyc.size()), 132'(11));
    chk("a_last_key", 132'(last_data), 132'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
    chk("a_first_latency", 132'(pop_cyc[0] - t0), 132'(4));
    spacing_ok = 1'b1;
    for (int k = 1; k < pop_cyc.size(); k++) if (pop_cyc[k] - pop_cyc[k-1] != 4) spacing_ok = 1'b0;
    chk("a_spacing_4", 132'(spacing_ok), 132'(1));
    chk_idle("a_idle_after_done");

    // Illegal mode
    illegal_start(2'b11, "illegal11");

`ifdef AES_KEYEXP_WIDE_KEY_EN
    start_run(2'b01, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0});
    wait_done(100, "m01");
    chk("m01_key_count", 132'(pop_cyc.size()), 132'(13));
    chk("m01_last_key", 132'(last_data), 132'(128'he98ba06f448c773c8ecc720401002202));
    chk("m01_sb_drained", 132'(exp_q.size()), 132'(0));
    start_run(2'b10, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
    wait_done(100, "m10");
    chk("m10_key_count", 132'(pop_cyc.size()), 132'(15));
    chk("m10_last_key", 132'(last_data), 132'(128'hfe4890d1e6188d0b046df344706c631e));
    chk("m10_sb_drained", 132'(exp_q.size()), 132'(0));
`else
    illegal_start(2'b10, "narrow_mode10");
    illegal_start(2'b01, "narrow_mode01");
`endif

    // Backpressure: consumer stalled for 40 cycles
    rk_ready = 1'b0;
    start_run(2'b00, KEY128);
    repeat (40) tick();
    @(negedge clk);
    chk("bp_valid_held", 132'(rk_valid), 132'(1));
    chk("bp_head_idx", 132'(rk_idx), 132'(0));
    chk("bp_busy", 132'(busy), 132'(1));
    rk_ready = 1'b1;
    wait_done(200, "bp");
    chk("bp_key_count", 132'(pop_cyc.size()), 132'(11));
    chk("bp_back_to_back", 132'(pop_cyc[1] - pop_cyc[0]), 132'(1));
    chk("bp_last_key", 132'(last_data), 132'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
    chk("bp_sb_drained", 132'(exp_q.size()), 132'(0));

    // Reset at cycle 20 of a run
    start_run(2'b00, KEY128);
    repeat (19) tick();
    d_before = n_done;
    rst = 1'b1; rk_ready = 1'b0;
    tick();
    rst = 1'b0; rk_ready = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk_idle("rst_mid_outputs_zero");
    chk("rst_mid_keys_before", 132'(pop_cyc.size()), 132'(4));
    repeat (30) tick();
    chk("rst_mid_no_done", 132'(n_done), 132'(d_before));
    chk_idle("rst_mid_still_idle");

    // Fresh run after reset; a start while busy must be ignored
    start_run(2'b00, KEYZ);
    repeat (5) tick();
    mode = 2'b11; key_in = KEY128; start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("busy_start_no_err", 132'(err), 132'(0));
    wait_done(80, "restart");
    chk("restart_key_count", 132'(pop_cyc.size()), 132'(11));
    chk("restart_sb_drained", 132'(exp_q.size()), 132'(0));
    chk_idle("restart_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
